aec_sched: RTL and testbench
============================

Name: aec_sched

Overview:
- Round-robin scheduler that shares one arithmetic-expression evaluator among NREQ requesters.
- Each requester streams ASCII expression characters with gaps allowed. The scheduler buffers one whole expression (up to 16 chars, terminated by '=') from the granted requester.
- It replays the buffered expression to the evaluator as a gap-free burst after a start pulse, waits for the evaluator's valid/result, and routes the result back to the owning requester.
- Sits between requester front-ends and the evaluator's clk/rst/ready/ascii_in/valid/result interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, max cycles in WAIT_RES before error response.
- ISSUE_GAP, 2, idle cycles after each response before a new grant, so the evaluator passes through its WAIT state.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request; held high until its rsp_valid.
- req_char  input  8*NREQ  flattened characters; requester i uses bits [8i+7:8i].
- req_char_vld  input  NREQ  character i valid this cycle.
- req_char_ack  output  NREQ  combinational; char i accepted this cycle.
- grant  output  NREQ  registered one-hot owner, 0 when none.
- eval_ready  output  1  one-cycle start pulse to the evaluator.
- eval_ascii  output  8  burst character to the evaluator.
- eval_valid  input  1  evaluator result strobe.
- eval_result  input  7  evaluator result.
- rsp_valid  output  NREQ  one-hot, one-cycle response strobe.
- rsp_result  output  7  result, valid with rsp_valid.
- rsp_err  output  1  error flag (overflow or timeout), valid with rsp_valid.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; buffer length 0.
- Reset applies in any state. Mid-operation it drops the grant with no response.
- The evaluator shares rst.

- Arbitration (IDLE):
  - Select the first i with req[i]=1, scanning cyclically from the pointer.
  - grant becomes one-hot the next cycle; the state moves to LOAD.
  - After a RESP or an abort, the pointer becomes (owner+1) mod NREQ.

- LOAD:
  - req_char_ack[i] = grant[i] & req_char_vld[i] & (state==LOAD or DRAIN).
  - Each accepted char is written to buf[len], then len+1.
  - Accepting '=' (0x3D) moves to ISSUE.
  - Accepting a 16th char that is not '=' sets the overflow flag and moves to DRAIN.

- DRAIN:
  - Accept and discard chars until '='.
  - Then go to RESP with rsp_err=1 and rsp_result=0.
  - Nothing is issued to the evaluator.

- Abort: req[owner] low in LOAD or DRAIN → discard the buffer, no response, advance the pointer, go to GAP.

- ISSUE:
  - eval_ready=1 for exactly one cycle (call it S).
  - In STREAM, eval_ascii = buf[k] in cycle S+1+k for k=0..len-1; the last char is '='.
  - eval_ascii = 0 outside STREAM.
  - Then go to WAIT_RES with the timer cleared.

- WAIT_RES:
  - eval_valid=1 → capture eval_result, go to RESP.
  - Timer reaching TIMEOUT → RESP with rsp_err=1 and rsp_result=0.
  - eval_valid in any other state is ignored.
  - req is not sampled after LOAD; no abort once issued.

- RESP:
  - rsp_valid[owner]=1 for one cycle, with rsp_result and rsp_err.
  - grant clears the following cycle.
  - Go to GAP.

- GAP: hold for ISSUE_GAP cycles, then go to IDLE.

- Simultaneous requests are resolved by the pointer only; a new req during a service waits.

- Latency for expression length L with no char gaps: req → grant 1 cycle; grant → last ack L cycles; +1 to eval_ready; +L burst; evaluator time; +1 to rsp_valid.

Test Plan:
- Req 0 streams 0x34,0x2B,0x35,0x3D with 2-cycle gaps; evaluator model returns 9 → one eval_ready pulse, burst 34 2B 35 3D on consecutive cycles, rsp_valid=0001, rsp_result=9, rsp_err=0.
- Req 0 and req 2 rise in the same cycle after reset → requester 0 served first, then 2. Then req 0, 1 and 2 all high → order is 0 (pointer now 1)... specifically pointer=3 wraps to 0, then 1, then 2.
- Requester 1 sends 17 chars "1+1+1+1+1+1+1+1+=" without '=' within the first 16 → DRAIN, no eval_ready, rsp_valid=0010, rsp_err=1, rsp_result=0.
- Evaluator model never asserts eval_valid → rsp_err=1 exactly TIMEOUT+1 cycles after entering WAIT_RES; a late eval_valid is ignored.
- Requester 3 drops req after 2 chars → grant clears, no rsp_valid, next requester granted after ISSUE_GAP cycles.
- Assert rst during STREAM → all outputs 0 the next cycle; a following "(2+3)*4=" on req 0 yields rsp_result=20.

Source files
------------

// File: rtl/aec_sched.sv
// Round-robin front end that buffers one '='-terminated expression per grant,
// replays it to a shared evaluator as a gap-free burst and routes the result back.
module aec_sched #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 255,
  parameter int ISSUE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_char,
  input  logic [NREQ-1:0]   req_char_vld,
  output logic [NREQ-1:0]   req_char_ack,
  output logic [NREQ-1:0]   grant,
  output logic              eval_ready,
  output logic [7:0]        eval_ascii,
  input  logic              eval_valid,
  input  logic [6:0]        eval_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [6:0]        rsp_result,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [7:0] EQ_CHAR = 8'h3D;

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, ISSUE, STREAM, WAIT_RES, RESP, GAP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      k_q, k_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [6:0]      res_q, res_d;
  logic            err_q, err_d;
  logic [7:0]      buf_q [16];

  logic            arb_hit;
  logic [IW-1:0]   arb_sel;
  logic [IW:0]     arb_idx;
  logic [7:0]      own_char;
  logic            own_req;
  logic            own_vld;
  logic [IW-1:0]   next_ptr;
  logic            wr_en;

  // Cyclic scan from the pointer; walking backwards lets the nearest requester win.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    arb_idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      arb_idx = {1'b0, ptr_q} + (IW+1)'(j);
      if (arb_idx >= (IW+1)'(NREQ)) arb_idx = arb_idx - (IW+1)'(NREQ);
      if (req[arb_idx[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_sel = arb_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    own_char = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) own_char = req_char[8*i +: 8];
    end
  end

  assign own_req  = req[owner_q];
  assign own_vld  = req_char_vld[owner_q] & grant_q[owner_q];
  assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    len_d   = len_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    res_d   = res_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          owner_d = arb_sel;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << arb_sel;
          len_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!own_req) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          gap_d   = '0;
          state_d = GAP;
        end else if (own_vld) begin
          wr_en = 1'b1;
          len_d = len_q + 5'd1;
          if (own_char == EQ_CHAR)   state_d = ISSUE;
          else if (len_q == 5'd15)   state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!own_req) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          gap_d   = '0;
          state_d = GAP;
        end else if (own_vld && own_char == EQ_CHAR) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ISSUE: begin
        k_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        k_d = k_q + 5'd1;
        if (k_q + 5'd1 == len_q) begin
          tmr_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (eval_valid) begin
          res_d   = eval_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_q == TW'(TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        ptr_d   = next_ptr;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        // ISSUE_GAP is at least 1: the evaluator needs an idle cycle to settle.
        if (gap_q == GW'(ISSUE_GAP - 1)) state_d = IDLE;
        else                             gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      len_q   <= '0;
      k_q     <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
    end
  end

  // Expression buffer and captured result are pure data; only qualified by state.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[len_q[3:0]] <= own_char;
    res_q <= res_d;
    err_q <= err_d;
  end

  assign req_char_ack = grant_q & req_char_vld &
                        {NREQ{(state_q == LOAD) || (state_q == DRAIN)}};
  assign grant        = grant_q;
  assign eval_ready   = (state_q == ISSUE);
  assign eval_ascii   = (state_q == STREAM) ? buf_q[k_q[3:0]] : 8'h00;
  assign rsp_valid    = (state_q == RESP) ? grant_q : '0;
  assign rsp_result   = (state_q == RESP) ? res_q : 7'd0;
  assign rsp_err      = (state_q == RESP) ? err_q : 1'b0;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aec_sched.sv
// Directed bench for aec_sched: requester drivers, a simple evaluator model and
// a scoreboard of expected bursts and responses.
module tb_aec_sched;
  localparam int NREQ      = 4;
  localparam int TIMEOUT   = 255;
  localparam int ISSUE_GAP = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_char = '0;
  logic [NREQ-1:0]   req_char_vld = '0;
  logic [NREQ-1:0]   req_char_ack;
  logic [NREQ-1:0]   grant;
  logic              eval_ready;
  logic [7:0]        eval_ascii;
  logic              eval_valid = 1'b0;
  logic [6:0]        eval_result = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [6:0]        rsp_result;
  logic              rsp_err;
  logic              busy;

  typedef struct {
    int         id;
    logic [6:0] res;
    logic       err;
  } rsp_t;

  logic [7:0] burst_q[$];
  rsp_t       rsp_q[$];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_ready = 0, exp_ready = 0;
  int eq_cyc = 0, rsp_cyc = 0, cnt = 0;
  bit in_burst = 1'b0, eval_silent = 1'b0, late_valid = 1'b0;

  aec_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_char(req_char),
    .req_char_vld(req_char_vld), .req_char_ack(req_char_ack), .grant(grant),
    .eval_ready(eval_ready), .eval_ascii(eval_ascii), .eval_valid(eval_valid),
    .eval_result(eval_result), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluator model plus burst/response scoreboard, all sampled on the falling edge.
  initial begin
    logic [7:0] exp_c;
    rsp_t       r;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_burst   = 1'b0;
        cnt        = 0;
        eval_valid = 1'b0;
        burst_q.delete();
        rsp_q.delete();
      end else begin
        if (cnt != 0) begin
          cnt--;
          eval_valid = (cnt == 0);
        end else begin
          eval_valid = late_valid;
        end
        if (in_burst) begin
          chk("burst_avail", burst_q.size() != 0, 1);
          if (burst_q.size() != 0) begin
            exp_c = burst_q.pop_front();
            chk("burst_char", eval_ascii, exp_c);
            if (exp_c == 8'h3D) begin
              in_burst = 1'b0;
              eq_cyc   = cyc;
              if (!eval_silent) cnt = 3;
            end
          end else begin
            in_burst = 1'b0;
          end
        end else begin
          chk("ascii_idle", eval_ascii, 0);
        end
        if (eval_ready) begin
          n_ready++;
          in_burst = 1'b1;
        end
        if (rsp_valid != 0) begin
          rsp_cyc = cyc;
          chk("rsp_avail", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("rsp_valid", rsp_valid, 1 << r.id);
            chk("rsp_result", rsp_result, r.res);
            chk("rsp_err", rsp_err, r.err);
          end
        end
      end
    end
  end

  task automatic send_char(input int id, input logic [7:0] c, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    req_char[8*id +: 8] = c;
    req_char_vld[id]    = 1'b1;
    #1;
    n = 0;
    while (!req_char_ack[id] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ack_wait", n < 100, 1);
    @(negedge clk);
    req_char_vld[id] = 1'b0;
  endtask

  task automatic send_expr(input int id, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_char(id, s[i], gap);
  endtask

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (grant == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant", grant, 1 << id);
  endtask

  task automatic wait_rsp(input int id, input int limit);
    int n;
    n = 0;
    while (!rsp_valid[id] && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", rsp_valid[id], 1);
    req[id] = 1'b0;
    #1;
  endtask

  // One full service: expected response/burst queued before the requester streams.
  task automatic serve(input int id, input string s, input logic [6:0] ret,
                       input logic err, input bit issued, input int gap, input int limit);
    eval_result = err ? 7'h55 : ret;
    rsp_q.push_back('{id, err ? 7'd0 : ret, err});
    if (issued) begin
      for (int i = 0; i < s.len(); i++) burst_q.push_back(s[i]);
      exp_ready++;
    end
    wait_grant(id);
    send_expr(id, s, gap);
    wait_rsp(id, limit);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    req_char_vld = '1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", eval_ready, 0);
    chk("rst_ascii", eval_ascii, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ack", req_char_ack, 0);
    req_char_vld = '0;
    @(negedge clk);
    rst = 1'b0;

    // Basic expression with gaps between characters.
    req[0] = 1'b1;
    serve(0, "4+5=", 7'd9, 1'b0, 1'b1, 2, 100);
    chk("lat_eval_to_rsp", rsp_cyc - eq_cyc, 4);
    chk("ready_cnt_t1", n_ready, exp_ready);

    // Round robin: 0 and 2 together, then 0,1,2 with the pointer at 3.
    do_reset();
    req[0] = 1'b1;
    req[2] = 1'b1;
    serve(0, "1+2=", 7'd3, 1'b0, 1'b1, 0, 100);
    serve(2, "2+2=", 7'd4, 1'b0, 1'b1, 0, 100);
    req[2:0] = 3'b111;
    serve(0, "3+3=", 7'd6, 1'b0, 1'b1, 0, 100);
    serve(1, "1+1=", 7'd2, 1'b0, 1'b1, 1, 100);
    serve(2, "8-1=", 7'd7, 1'b0, 1'b1, 0, 100);

    // 17 characters: overflow after the 16th, drained, error response, nothing issued.
    req[1] = 1'b1;
    serve(1, "1+1+1+1+1+1+1+1+=", 7'd0, 1'b1, 1'b0, 0, 100);
    chk("ready_cnt_ovf", n_ready, exp_ready);

    // Exactly 16 characters ending in '=' fits the buffer.
    req[2] = 1'b1;
    serve(2, "1+1+1+1+1+1+111=", 7'd117, 1'b0, 1'b1, 0, 100);

    // Evaluator silent: timeout error, then a late strobe must be ignored.
    eval_silent = 1'b1;
    req[3] = 1'b1;
    serve(3, "7=", 7'd0, 1'b1, 1'b1, 0, 400);
    chk("timeout_lat", rsp_cyc - eq_cyc, TIMEOUT + 2);
    eval_silent = 1'b0;
    late_valid  = 1'b1;
    repeat (2) @(negedge clk);
    late_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("late_idle_busy", busy, 0);
    chk("late_idle_rsp", rsp_valid, 0);

    // Abort: requester 3 drops after two characters, requester 0 waits behind it.
    req[3] = 1'b1;
    wait_grant(3);
    send_char(3, 8'h31, 0);
    send_char(3, 8'h2B, 0);
    req[3] = 1'b0;
    req[0] = 1'b1;
    @(negedge clk);
    chk("abort_grant_clear", grant, 0);
    n = 1;
    while (grant == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_regrant_cyc", n, ISSUE_GAP + 2);
    chk("abort_regrant", grant, 4'b0001);

    // Reset in the middle of a burst, then a fresh expression on requester 0.
    eval_result = 7'd10;
    for (int i = 0; i < 8; i++) burst_q.push_back(8'h00);
    burst_q.delete();
    begin
      string s;
      s = "1+2+3+4=";
      for (int i = 0; i < s.len(); i++) burst_q.push_back(s[i]);
      rsp_q.push_back('{0, 7'd10, 1'b0});
      exp_ready++;
      send_expr(0, s, 0);
    end
    n = 0;
    while (!eval_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ready_seen", eval_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", eval_ready, 0);
    chk("mid_rst_ascii", eval_ascii, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_ack", req_char_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    serve(0, "(2+3)*4=", 7'd20, 1'b0, 1'b1, 0, 100);
    chk("ready_cnt_final", n_ready, exp_ready);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
